// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle CPU control unit.
//   - opcode values of the supported instruction set
//   - FSM state encodings (visible on the debug 'state' port)
//   - instruction class produced by the opcode decoder
//   - ALUOp and PCSrc select codes driven into the datapath
package multicycle_pkg;

    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPC_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b000010;
    localparam logic [OPC_W-1:0] OP_OR    = 6'b010000;
    localparam logic [OPC_W-1:0] OP_AND   = 6'b010001;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b010010;
    localparam logic [OPC_W-1:0] OP_SLL   = 6'b011000;
    localparam logic [OPC_W-1:0] OP_SLT   = 6'b100110;
    localparam logic [OPC_W-1:0] OP_SLTIU = 6'b100111;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b110000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OPC_W-1:0] OP_J     = 6'b111000;
    localparam logic [OPC_W-1:0] OP_JR    = 6'b111001;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'b111010;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP, CL_ALU, CL_ALUI, CL_LW, CL_SW,
        CL_BEQ, CL_J, CL_JR, CL_JAL, CL_HALT
    } iclass_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

endpackage

// File: rtl/cu_opcode_decode.sv
// Combinational opcode decoder.
//   opcode    : IR[31:26]
//   cls       : instruction class (iclass_t encoding)
//   alu_op    : ALU operation for the execute/memory-address phase
//   ext_sel   : 1 = sign-extend imm16, 0 = zero-extend
//   alu_src_a : 1 = shift amount instead of rs
//   alu_src_b : 1 = extended immediate instead of rt
module cu_opcode_decode
    import multicycle_pkg::*;
#(
    parameter int                  OPCODE_W = 6,
    parameter logic [OPCODE_W-1:0] HALT_OP  = 6'b111111
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic [3:0]          cls,
    output logic [2:0]          alu_op,
    output logic                ext_sel,
    output logic                alu_src_a,
    output logic                alu_src_b
);

    always_comb begin
        cls       = CL_NOP;
        alu_op    = ALU_ADD;
        ext_sel   = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        if (opcode == HALT_OP) begin
            cls = CL_HALT;
        end else begin
            case (opcode)
                OP_ADD:   begin cls = CL_ALU;  alu_op = ALU_ADD; end
                OP_SUB:   begin cls = CL_ALU;  alu_op = ALU_SUB; end
                OP_OR:    begin cls = CL_ALU;  alu_op = ALU_OR;  end
                OP_AND:   begin cls = CL_ALU;  alu_op = ALU_AND; end
                OP_SLT:   begin cls = CL_ALU;  alu_op = ALU_SLT; end
                OP_SLL:   begin cls = CL_ALU;  alu_op = ALU_SLL; alu_src_a = 1'b1; end
                OP_ADDI:  begin cls = CL_ALUI; alu_op = ALU_ADD;  alu_src_b = 1'b1; ext_sel = 1'b1; end
                OP_ORI:   begin cls = CL_ALUI; alu_op = ALU_OR;   alu_src_b = 1'b1; end
                OP_SLTIU: begin cls = CL_ALUI; alu_op = ALU_SLTU; alu_src_b = 1'b1; ext_sel = 1'b1; end
                OP_LW:    begin cls = CL_LW;   alu_op = ALU_ADD;  alu_src_b = 1'b1; ext_sel = 1'b1; end
                OP_SW:    begin cls = CL_SW;   alu_op = ALU_ADD;  alu_src_b = 1'b1; ext_sel = 1'b1; end
                OP_BEQ:   begin cls = CL_BEQ;  alu_op = ALU_SUB;  ext_sel = 1'b1; end
                OP_J:     cls = CL_J;
                OP_JR:    cls = CL_JR;
                OP_JAL:   cls = CL_JAL;
                default:  cls = CL_NOP;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Sequencing FSM for the multicycle CPU datapath.
//   clk, reset (async, active-low)
//   opcode, zero          : IR opcode and ALU zero flag
//   PCWre..PCSrc          : datapath enables and mux selects (combinational)
//   state                 : current FSM state (debug)
//   halted                : set by HALT_OP, cleared only by reset
module multicycle_control_unit
    import multicycle_pkg::*;
#(
    parameter int                  OPCODE_W = 6,
    parameter logic [OPCODE_W-1:0] HALT_OP  = 6'b111111
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                PCWre,
    output logic                IRWre,
    output logic                InsMemRW,
    output logic                ALUSrcA,
    output logic                ALUSrcB,
    output logic [2:0]          ALUOp,
    output logic                ExtSel,
    output logic                RegWre,
    output logic [1:0]          RegDst,
    output logic                WrRegDSrc,
    output logic                DBDataSrc,
    output logic                mRD,
    output logic                mWR,
    output logic [1:0]          PCSrc,
    output logic [2:0]          state,
    output logic                halted
);

    state_t     state_q, state_d;
    logic       halted_q, halted_d;
    logic [3:0] cls;
    logic [2:0] dec_alu_op;
    logic       dec_ext, dec_src_a, dec_src_b;

    cu_opcode_decode #(
        .OPCODE_W(OPCODE_W),
        .HALT_OP (HALT_OP)
    ) u_decode (
        .opcode   (opcode),
        .cls      (cls),
        .alu_op   (dec_alu_op),
        .ext_sel  (dec_ext),
        .alu_src_a(dec_src_a),
        .alu_src_b(dec_src_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IF;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (halted_q) begin
                    state_d = S_ID;
                end else begin
                    case (cls)
                        CL_ALU, CL_ALUI: state_d = S_EXE_AL;
                        CL_BEQ:          state_d = S_EXE_BR;
                        CL_LW, CL_SW:    state_d = S_EXE_LS;
                        CL_HALT: begin
                            state_d  = S_ID;
                            halted_d = 1'b1;
                        end
                        default:         state_d = S_IF;
                    endcase
                end
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = (cls == CL_LW) ? S_WB_LD : S_IF;
            S_WB_LD:  state_d = S_IF;
            default:  state_d = S_IF;
        endcase
    end

    always_comb begin
        // The PC advances on the last cycle of every instruction, which is
        // exactly the cycle whose successor is IF; halt never returns to IF.
        PCWre     = (state_d == S_IF);
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        ExtSel    = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = PC_NEXT;
        case (state_q)
            S_IF: begin
                IRWre    = 1'b1;
                InsMemRW = 1'b1;
            end
            S_ID: begin
                if (!halted_q) begin
                    case (cls)
                        CL_J:  PCSrc = PC_JUMP;
                        CL_JR: PCSrc = PC_RS;
                        CL_JAL: begin
                            PCSrc  = PC_JUMP;
                            RegWre = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_EXE_AL, S_WB_AL: begin
                // ALU selects are held through write-back so the result stays valid.
                ALUSrcA = dec_src_a;
                ALUSrcB = dec_src_b;
                ALUOp   = dec_alu_op;
                ExtSel  = dec_ext;
                if (state_q == S_WB_AL) begin
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    RegDst    = (cls == CL_ALU) ? 2'b10 : 2'b01;
                end
            end
            S_EXE_BR: begin
                ALUOp  = dec_alu_op;
                ExtSel = dec_ext;
                PCSrc  = zero ? PC_BRANCH : PC_NEXT;
            end
            S_EXE_LS, S_MEM, S_WB_LD: begin
                // Address computation held until the access completes.
                ALUSrcB = dec_src_b;
                ALUOp   = dec_alu_op;
                ExtSel  = dec_ext;
                if (state_q == S_MEM) begin
                    mRD = (cls == CL_LW);
                    mWR = (cls == CL_SW);
                end
                if (state_q == S_WB_LD) begin
                    DBDataSrc = 1'b1;
                    RegDst    = 2'b01;
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign state  = state_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    typedef struct packed {
        logic [2:0] st;
        logic       halted;
        logic       pcwre;
        logic       irwre;
        logic       insmem;
        logic       srca;
        logic       srcb;
        logic [2:0] aluop;
        logic       ext;
        logic       regwre;
        logic [1:0] regdst;
        logic       wrsrc;
        logic       dbsrc;
        logic       mrd;
        logic       mwr;
        logic [1:0] pcsrc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'b000000;
    logic       zero = 1'b0;
    logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, RegWre;
    logic       WrRegDSrc, DBDataSrc, mRD, mWR, halted;
    logic [2:0] ALUOp, state;
    logic [1:0] RegDst, PCSrc;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_control_unit #(
        .OPCODE_W(6),
        .HALT_OP (6'b111111)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .zero     (zero),
        .PCWre    (PCWre),
        .IRWre    (IRWre),
        .InsMemRW (InsMemRW),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .ExtSel   (ExtSel),
        .RegWre   (RegWre),
        .RegDst   (RegDst),
        .WrRegDSrc(WrRegDSrc),
        .DBDataSrc(DBDataSrc),
        .mRD      (mRD),
        .mWR      (mWR),
        .PCSrc    (PCSrc),
        .state    (state),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sample(output exp_t o);
        o.st     = state;
        o.halted = halted;
        o.pcwre  = PCWre;
        o.irwre  = IRWre;
        o.insmem = InsMemRW;
        o.srca   = ALUSrcA;
        o.srcb   = ALUSrcB;
        o.aluop  = ALUOp;
        o.ext    = ExtSel;
        o.regwre = RegWre;
        o.regdst = RegDst;
        o.wrsrc  = WrRegDSrc;
        o.dbsrc  = DBDataSrc;
        o.mrd    = mRD;
        o.mwr    = mWR;
        o.pcsrc  = PCSrc;
    endtask

    function automatic exp_t blank(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t vif();
        exp_t e;
        e = blank(3'b000);
        e.irwre  = 1'b1;
        e.insmem = 1'b1;
        return e;
    endfunction

    // Hand-written expected per-cycle control vectors for one instruction,
    // starting with its IF cycle.
    task automatic push_instr(input logic [5:0] op, input logic z);
        exp_t e;
        sb.push_back(vif());
        case (op)
            6'b000000, 6'b000001, 6'b010000, 6'b010001, 6'b011000, 6'b100110,
            6'b000010, 6'b010010, 6'b100111: begin
                sb.push_back(blank(3'b001));
                e = blank(3'b110);
                case (op)
                    6'b000001: e.aluop = 3'b001;
                    6'b010000: e.aluop = 3'b011;
                    6'b010001: e.aluop = 3'b100;
                    6'b011000: begin e.aluop = 3'b010; e.srca = 1'b1; end
                    6'b100110: e.aluop = 3'b101;
                    6'b000010: begin e.srcb = 1'b1; e.ext = 1'b1; end
                    6'b010010: begin e.aluop = 3'b011; e.srcb = 1'b1; end
                    6'b100111: begin e.aluop = 3'b110; e.srcb = 1'b1; e.ext = 1'b1; end
                    default: ;
                endcase
                sb.push_back(e);
                e.st     = 3'b111;
                e.regwre = 1'b1;
                e.wrsrc  = 1'b1;
                e.pcwre  = 1'b1;
                e.regdst = e.srcb ? 2'b01 : 2'b10;
                sb.push_back(e);
            end
            6'b110001, 6'b110000: begin
                sb.push_back(blank(3'b001));
                e = blank(3'b010);
                e.srcb = 1'b1;
                e.ext  = 1'b1;
                sb.push_back(e);
                e.st = 3'b011;
                if (op == 6'b110001) e.mrd = 1'b1;
                else begin e.mwr = 1'b1; e.pcwre = 1'b1; end
                sb.push_back(e);
                if (op == 6'b110001) begin
                    e.st     = 3'b100;
                    e.mrd    = 1'b0;
                    e.dbsrc  = 1'b1;
                    e.regdst = 2'b01;
                    e.regwre = 1'b1;
                    e.wrsrc  = 1'b1;
                    e.pcwre  = 1'b1;
                    sb.push_back(e);
                end
            end
            6'b110100: begin
                sb.push_back(blank(3'b001));
                e = blank(3'b101);
                e.aluop = 3'b001;
                e.ext   = 1'b1;
                e.pcwre = 1'b1;
                e.pcsrc = z ? 2'b01 : 2'b00;
                sb.push_back(e);
            end
            6'b111000, 6'b111001, 6'b111010: begin
                e = blank(3'b001);
                e.pcwre = 1'b1;
                e.pcsrc = (op == 6'b111001) ? 2'b10 : 2'b11;
                if (op == 6'b111010) e.regwre = 1'b1;
                sb.push_back(e);
            end
            default: begin
                e = blank(3'b001);
                e.pcwre = 1'b1;
                sb.push_back(e);
            end
        endcase
    endtask

    task automatic test_reset();
        exp_t e, o;
        reset = 1'b0;
        tick();
        tick();
        e = vif();
        sample(o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_state got %h want %h", o, e);
        end
        reset = 1'b1;
    endtask

    task automatic test_alu();
        logic [5:0] ops [9];
        exp_t e, o;
        ops = '{6'b000000, 6'b000001, 6'b010000, 6'b010001, 6'b011000,
                6'b100110, 6'b000010, 6'b010010, 6'b100111};
        for (int i = 0; i < 9; i++) begin
            opcode = ops[i];
            push_instr(ops[i], 1'b0);
            for (int c = 0; sb.size() > 0; c++) begin
                e = sb.pop_front();
                sample(o);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL alu op=%b cyc%0d got %h want %h", ops[i], c, o, e);
                end
                tick();
            end
        end
    endtask

    task automatic test_load_store();
        exp_t e, o;
        for (int i = 0; i < 2; i++) begin
            opcode = (i == 0) ? 6'b110001 : 6'b110000;
            push_instr(opcode, 1'b0);
            for (int c = 0; sb.size() > 0; c++) begin
                e = sb.pop_front();
                sample(o);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL ldst op=%b cyc%0d got %h want %h", opcode, c, o, e);
                end
                tick();
            end
        end
    endtask

    task automatic test_branch();
        exp_t e, o;
        for (int i = 0; i < 2; i++) begin
            opcode = 6'b110100;
            zero   = (i == 0);
            push_instr(opcode, zero);
            for (int c = 0; sb.size() > 0; c++) begin
                e = sb.pop_front();
                sample(o);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL beq zero=%b cyc%0d got %h want %h", zero, c, o, e);
                end
                tick();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jumps();
        logic [5:0] ops [4];
        exp_t e, o;
        ops = '{6'b111000, 6'b111001, 6'b111010, 6'b101010};
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i];
            push_instr(ops[i], 1'b0);
            for (int c = 0; sb.size() > 0; c++) begin
                e = sb.pop_front();
                sample(o);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL jump op=%b cyc%0d got %h want %h", ops[i], c, o, e);
                end
                tick();
            end
        end
    endtask

    task automatic test_halt();
        exp_t e, o;
        opcode = 6'b111111;
        sb.push_back(vif());
        sb.push_back(blank(3'b001));
        e = blank(3'b001);
        e.halted = 1'b1;
        for (int i = 0; i < 20; i++) sb.push_back(e);
        for (int c = 0; sb.size() > 0; c++) begin
            e = sb.pop_front();
            sample(o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL halt cyc%0d got %h want %h", c, o, e);
            end
            tick();
        end
        // asynchronous reset releases the parked machine immediately
        reset = 1'b0;
        #1;
        e = vif();
        sample(o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL halt_reset got %h want %h", o, e);
        end
        @(negedge clk);
        reset = 1'b1;
        opcode = 6'b101010;
        push_instr(opcode, 1'b0);
        for (int c = 0; sb.size() > 0; c++) begin
            e = sb.pop_front();
            sample(o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL post_halt_nop cyc%0d got %h want %h", c, o, e);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        opcode = 6'b000000;
        sb.push_back(vif());
        sb.push_back(blank(3'b001));
        for (int c = 0; sb.size() > 0; c++) begin
            e = sb.pop_front();
            sample(o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rstmid_pre cyc%0d got %h want %h", c, o, e);
            end
            tick();
        end
        e = blank(3'b110);
        sample(o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL rstmid_exe got %h want %h", o, e);
        end
        #1;
        reset = 1'b0;
        #1;
        e = vif();
        sample(o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL rstmid_async got %h want %h", o, e);
        end
        @(negedge clk);
        reset = 1'b1;
        push_instr(opcode, 1'b0);
        for (int c = 0; sb.size() > 0; c++) begin
            e = sb.pop_front();
            sample(o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rstmid_resume cyc%0d got %h want %h", c, o, e);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [16];
        exp_t e, o;
        ops = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
                6'b011000, 6'b100110, 6'b100111, 6'b110000, 6'b110001, 6'b110100,
                6'b111000, 6'b111001, 6'b111010, 6'b001111};
        for (int i = 0; i < 24; i++) begin
            opcode = ops[$urandom_range(0, 15)];
            zero   = 1'($urandom_range(0, 1));
            push_instr(opcode, zero);
            for (int c = 0; sb.size() > 0; c++) begin
                e = sb.pop_front();
                sample(o);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL b2b op=%b z=%b cyc%0d got %h want %h", opcode, zero, c, o, e);
                end
                tick();
            end
        end
        e = vif();
        sample(o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL b2b_final got %h want %h", o, e);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_jumps();
        test_back_to_back();
        test_reset_mid();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
